// File: rtl/pifbridge_pkg.sv
// pifbridge_pkg
// Shared definitions for the pifbridge byte-command bridge.
// Contents:
//   OP_SETADDR / OP_WRITE : opcodes carried in rx_data[7:6]
//   PB_READ_LAT           : default XO readback latency of pifctl
//   CNT_W                 : settle counter width (covers READ_LAT 1..7)
//   pb_state_t            : read-sequence FSM states
package pifbridge_pkg;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;

  localparam int PB_READ_LAT = 2;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    PB_IDLE    = 2'd0,
    PB_RD_WAIT = 2'd1,
    PB_RD_SEND = 2'd2,
    PB_RD_DONE = 2'd3
  } pb_state_t;

endpackage

// File: rtl/pifbridge_settle.sv
// pifbridge_settle
// Loadable saturating down-counter that tracks how long pifctl's XO bus
// still needs to settle after an address or sub-address change.
// Ports:
//   xclk    in  system clock
//   sys_rst in  asynchronous active-low reset (counter restarts at LAT)
//   load    in  reload the counter with LAT
//   count   in  decrement enable (saturates at 0)
//   zero    out counter is 0: XO may be trusted
module pifbridge_settle
  import pifbridge_pkg::*;
#(
  parameter int LAT = PB_READ_LAT
) (
  input  logic xclk,
  input  logic sys_rst,
  input  logic load,
  input  logic count,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // Coming out of reset the bus contents are unknown, so start fully unsettled.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= CNT_W'(LAT);
    end else if (load) begin
      cnt <= CNT_W'(LAT);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pifbridge.sv
// pifbridge
// Byte-level command bridge between the I2C slave byte engine and pifctl.
// Received bytes become XI address updates or write strobes; read requests
// are served from XO once pifctl's registered readback has settled.
// Ports:
//   xclk, sys_rst        clock, asynchronous active-low reset
//   i2c_start, i2c_stop  bus condition pulses
//   rx_valid, rx_data    received byte (opcode in [7:6])
//   tx_req               master wants a read byte
//   tx_valid, tx_data    read byte handed to the byte engine
//   XO                   pifctl readback bus
//   XI_PWr, XI_PD        write strobe and write data
//   XI_PRWA, XI_PRdSubA  register address and read sub-address
//   XI_PRdFinished       read byte consumed
//   proto_err            protocol violation pulse
module pifbridge
  import pifbridge_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int SUBA_W   = 4,
  parameter int DATA_W   = 6,
  parameter int READ_LAT = PB_READ_LAT
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_req,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic [7:0]        XO,
  output logic              XI_PWr,
  output logic [ADDR_W-1:0] XI_PRWA,
  output logic              XI_PRdFinished,
  output logic [SUBA_W-1:0] XI_PRdSubA,
  output logic [DATA_W-1:0] XI_PD,
  output logic              proto_err
);

  pb_state_t         state;
  logic [1:0]        rx_op;
  logic              rx_accept;
  logic              do_setaddr;
  logic              do_write;
  logic              rd_advance;
  logic              bad_event;
  logic [ADDR_W-1:0] addr_nxt;
  logic [SUBA_W-1:0] suba_nxt;
  logic              settle_load;
  logic              settle_zero;

  assign rx_op      = rx_data[7:6];
  // Bytes are only decoded while no read is in flight.
  assign rx_accept  = rx_valid && (state == PB_IDLE);
  assign do_setaddr = rx_accept && (rx_op == OP_SETADDR);
  assign do_write   = rx_accept && (rx_op == OP_WRITE);
  assign rd_advance = (state == PB_RD_DONE);
  assign bad_event  = (rx_valid && ((state != PB_IDLE) || rx_op[1])) ||
                      (tx_req && (state != PB_IDLE));

  always_comb begin
    addr_nxt = XI_PRWA;
    suba_nxt = XI_PRdSubA;
    if (do_setaddr) begin
      addr_nxt = rx_data[ADDR_W-1:0];
      suba_nxt = '0;
    end else if (rd_advance) begin
      suba_nxt = XI_PRdSubA + SUBA_W'(1);
    end
  end

  // Only a real change of the address pair invalidates the XO pipeline.
  assign settle_load = (addr_nxt != XI_PRWA) || (suba_nxt != XI_PRdSubA);

  pifbridge_settle #(
    .LAT(READ_LAT)
  ) u_settle (
    .xclk   (xclk),
    .sys_rst(sys_rst),
    .load   (settle_load),
    .count  (1'b1),
    .zero   (settle_zero)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so tx_valid is high exactly while in RD_SEND and XI_PRdFinished while in
  // RD_DONE. A request arriving with i2c_start is treated as cleared.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state          <= PB_IDLE;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= '0;
      XI_PRdFinished <= 1'b0;
      XI_PRdSubA     <= '0;
      XI_PD          <= '0;
      proto_err      <= 1'b0;
    end else begin
      tx_valid       <= 1'b0;
      XI_PRdFinished <= 1'b0;
      XI_PWr         <= do_write;
      proto_err      <= bad_event;
      XI_PRWA        <= addr_nxt;
      XI_PRdSubA     <= suba_nxt;
      if (do_write) begin
        XI_PD <= rx_data[DATA_W-1:0];
      end
      case (state)
        PB_IDLE: begin
          if (tx_req && !i2c_start) begin
            state <= PB_RD_WAIT;
          end
        end
        PB_RD_WAIT: begin
          if (i2c_stop || i2c_start) begin
            state <= PB_IDLE;
          end else if (settle_zero) begin
            tx_data  <= XO;
            tx_valid <= 1'b1;
            state    <= PB_RD_SEND;
          end
        end
        PB_RD_SEND: begin
          XI_PRdFinished <= 1'b1;
          state          <= PB_RD_DONE;
        end
        PB_RD_DONE: begin
          state <= PB_IDLE;
        end
        default: begin
          state <= PB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pifbridge.sv
// tb_pifbridge
// Directed bench for pifbridge. XO is modelled as pifctl's two-stage
// registered readback of a sub-address indexed table; expected read bytes
// are queued when a request is issued and checked when tx_valid appears.
module tb_pifbridge;

  logic        xclk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        i2c_start = 1'b0;
  logic        i2c_stop = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_req = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [7:0]  XO = 8'h00;
  logic        XI_PWr;
  logic [5:0]  XI_PRWA;
  logic        XI_PRdFinished;
  logic [3:0]  XI_PRdSubA;
  logic [5:0]  XI_PD;
  logic        proto_err;

  int tests = 0;
  int fails = 0;
  int n_tx = 0;
  int n_fin = 0;
  int snap_tx;
  int snap_fin;
  int k;

  logic [7:0] rom [16] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69,
                           8'h11, 8'h22, 8'h44, 8'h88, 8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] xo_s1 = 8'h00;
  logic [7:0] sb_q [$];

  pifbridge dut (
    .xclk          (xclk),
    .sys_rst       (sys_rst),
    .i2c_start     (i2c_start),
    .i2c_stop      (i2c_stop),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_req        (tx_req),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .XO            (XO),
    .XI_PWr        (XI_PWr),
    .XI_PRWA       (XI_PRWA),
    .XI_PRdFinished(XI_PRdFinished),
    .XI_PRdSubA    (XI_PRdSubA),
    .XI_PD         (XI_PD),
    .proto_err     (proto_err)
  );

  always #5 xclk = ~xclk;

  // pifctl readback model: two register stages behind the sub-address.
  always @(posedge xclk) begin
    xo_s1 <= rom[XI_PRdSubA];
    XO    <= xo_s1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every tx_valid must match the oldest queued byte.
  always @(negedge xclk) begin
    if (tx_valid === 1'b1) begin
      n_tx++;
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_tx", sb_q.size(), 1);
      end else begin
        checkOutput("sb_data", tx_data, sb_q.pop_front());
      end
    end
    if (XI_PRdFinished === 1'b1) n_fin++;
  end

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic applyStimulus(input logic rxv, input logic [7:0] rxd, input logic txr,
                               input logic sta, input logic sto);
    rx_valid  = rxv;
    rx_data   = rxd;
    tx_req    = txr;
    i2c_start = sta;
    i2c_stop  = sto;
    tick();
    rx_valid  = 1'b0;
    tx_req    = 1'b0;
    i2c_start = 1'b0;
    i2c_stop  = 1'b0;
  endtask

  // Returns once the sub-address advance is visible (bridge back in IDLE).
  task automatic waitRead(input string tag, input int exp_lat, input int exp_suba);
    int c;
    c = 0;
    while (tx_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checkOutput({tag, "_latency"}, c, exp_lat);
    if (c < 20) begin
      tick();
      checkOutput({tag, "_finished"}, {tx_valid, XI_PRdFinished}, 2'b01);
      tick();
      checkOutput({tag, "_suba"}, XI_PRdSubA, (exp_suba + 1) % 16);
    end
  endtask

  task automatic doRead(input string tag, input logic rxv, input logic [7:0] rxd,
                        input int exp_lat, input int exp_suba);
    sb_q.push_back(rom[exp_suba]);
    applyStimulus(rxv, rxd, 1'b1, 1'b0, 1'b0);
    waitRead(tag, exp_lat, exp_suba);
  endtask

  function automatic logic [31:0] allOutputs();
    return {4'h0, tx_valid, tx_data, XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD, proto_err};
  endfunction

  initial begin
    // Reset values
    repeat (3) tick();
    checkOutput("reset_outputs", allOutputs(), 32'h0);
    sys_rst = 1'b1;
    tick();

    // SETADDR then WRITE 0x55 -> data 0x15
    applyStimulus(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
    checkOutput("setaddr_2a", {proto_err, XI_PRWA}, {1'b0, 6'h2A});
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("setaddr_00", {proto_err, XI_PRWA}, {1'b0, 6'h00});
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("write_strobe", {proto_err, XI_PWr, XI_PD}, {1'b0, 1'b1, 6'h15});
    tick();
    checkOutput("write_hold", {XI_PWr, XI_PD, XI_PRWA}, {1'b0, 6'h15, 6'h00});

    // Settled read: tx_valid at n+2, finished at n+3
    repeat (5) tick();
    doRead("settled", 1'b0, 8'h00, 1, 0);

    // 17 back-to-back reads through the sub-address wrap
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      doRead($sformatf("b2b%0d", i), 1'b0, 8'h00, 2, i % 16);
    end

    // Illegal opcode leaves XI state alone
    repeat (5) tick();
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    checkOutput("bad_opcode", {proto_err, XI_PWr, XI_PRWA, XI_PRdSubA, XI_PD},
                {1'b1, 1'b0, 6'h05, 4'h1, 6'h15});
    tick();
    checkOutput("bad_opcode_pulse", proto_err, 1'b0);

    // Second tx_req while in RD_WAIT is dropped; the first completes
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(rom[0]);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("txreq_in_wait", proto_err, 1'b1);
    waitRead("txreq_in_wait", 1, 0);

    // STOP during RD_WAIT aborts the read without side effects
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    snap_tx  = n_tx;
    snap_fin = n_fin;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    checkOutput("stop_abort_counts", {n_tx[15:0], n_fin[15:0]}, {snap_tx[15:0], snap_fin[15:0]});
    checkOutput("stop_abort_suba", XI_PRdSubA, 4'h0);
    doRead("after_abort", 1'b0, 8'h00, 1, 0);

    // Byte arriving during RD_WAIT is dropped
    sb_q.push_back(rom[1]);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    checkOutput("rx_in_wait", {proto_err, XI_PRWA}, {1'b1, 6'h07});
    waitRead("rx_in_wait", 1, 1);

    // SETADDR and tx_req in the same cycle: fresh latency applies
    doRead("same_cycle", 1'b1, 8'h0A, 3, 0);
    checkOutput("same_cycle_addr", XI_PRWA, 6'h0A);

    // Asynchronous reset mid RD_WAIT, then a fresh read
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    sys_rst = 1'b0;
    #1;
    checkOutput("async_reset", allOutputs(), 32'h0);
    tick();
    tick();
    sys_rst = 1'b1;
    doRead("post_reset", 1'b0, 8'h00, 2, 0);

    repeat (3) tick();
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
